alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Per-thread arithmetic unit for the compute core. Parametrised data width, valid/ready request and response handshakes, and a multi-cycle restoring divider.
- Executes ADD/SUB/MUL/DIV and an NZP compare.
- Sits between the register file read stage and the register writeback/NZP update. The core scheduler waits on resp_valid instead of assuming a fixed EXECUTE latency.

Parameters:
- DATA_WIDTH, 8: operand and result width in bits (>= 4).
- SIGNED_CMP, 1: 1 = compare treats operands as two's complement; 0 = unsigned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  thread active; low blocks new requests only
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- req_cmp  in  1  1 = compare operation (req_op ignored)
- rs  in  DATA_WIDTH  operand A
- rt  in  DATA_WIDTH  operand B
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  arithmetic result, or {0…, P, Z, N} for compare
- div_by_zero  out  1  qualifies result; high when a DIV had rt == 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is reset, synchronous, active-high.
  - Reset forces state IDLE. req_ready, resp_valid, div_by_zero and busy go to 0 and result goes to 0 on the next edge.
  - Reset during DIVIDE or DONE aborts the operation; no response is produced.
- States are IDLE, DIVIDE and DONE.
- IDLE:
  - req_ready = enable.
  - Accept occurs on req_valid && req_ready; operands and opcode are captured at that edge.
  - ADD, SUB, MUL and compare: result is computed at the accept edge and the state moves to DONE. resp_valid is high the cycle after accept (latency 1).
  - DIV with rt != 0: moves to DIVIDE and initialises quotient = rs, remainder = 0, counter = DATA_WIDTH.
  - DIV with rt == 0: moves directly to DONE with result all ones and div_by_zero = 1 (latency 1).
- DIVIDE:
  - Unsigned restoring division, one quotient bit per cycle, exactly DATA_WIDTH cycles.
  - When the counter reaches 0, moves to DONE with result = quotient and the remainder discarded.
  - Total DIV latency is DATA_WIDTH + 1 cycles from the accept edge to resp_valid.
- DONE:
  - resp_valid = 1. result and div_by_zero hold stable until a handshake with resp_ready.
  - resp_ready high: returns to IDLE; resp_valid drops the next cycle.
  - No request is accepted in the same cycle as the response handshake: req_ready is low outside IDLE. Back-to-back throughput for single-cycle ops is therefore 1 op per 2 cycles.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^DATA_WIDTH; MUL returns the low DATA_WIDTH bits.
  - DIV is unsigned.
  - div_by_zero is 0 for every non-DIV op and for a DIV with rt != 0.
- Compare:
  - result[2] = P (rs > rt), result[1] = Z (rs == rt), result[0] = N (rs < rt). Upper bits are 0.
  - Exactly one of P, Z, N is set.
  - Signedness follows SIGNED_CMP.
- enable:
  - enable low in IDLE: req_ready = 0 and requests are ignored.
  - enable low in DIVIDE or DONE: the in-flight operation continues and the response is still delivered.
- busy = (state != IDLE).

Test Plan:
- Reset, then ADD rs=200, rt=100 (DATA_WIDTH=8) -> resp_valid exactly 1 cycle after accept, result=44 (wrap), div_by_zero=0.
- MUL rs=20, rt=13 -> result=4 (260 mod 256). SUB rs=3, rt=5 -> result=254.
- DIV rs=200, rt=7 -> resp_valid asserted exactly 9 cycles after accept, result=28. Hold resp_ready low 3 cycles -> result held stable, req_ready=0 throughout. DIV rs=5, rt=0 -> result=255, div_by_zero=1, latency 1.
- Compare with SIGNED_CMP=1, rs=0xFF, rt=0x01 -> result=0x01 (N). Same operands with SIGNED_CMP=0 -> result=0x04 (P). rs=rt=0x42 -> 0x02.
- Assert reset at cycle 4 of a DIV -> busy=0, resp_valid=0, result=0 the next cycle. A new ADD 1+1 is then accepted and returns 2.
- enable=0 with req_valid=1 in IDLE -> no accept, resp_valid stays 0. Start a DIV, then drop enable mid-divide -> the response is still delivered with the correct quotient.

Source files
------------

// File: rtl/alu_iterative.sv
// Per-thread ALU: single-cycle ADD/SUB/MUL/compare, multi-cycle restoring divider,
// with valid/ready handshakes on both the request and response sides.
module alu_iterative #(
    parameter int DATA_WIDTH = 8,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic                  req_cmp,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_by_zero,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] result_reg, result_next;
    logic [DATA_WIDTH-1:0] quot_reg, quot_next;
    logic [DATA_WIDTH-1:0] rem_reg, rem_next;
    logic [DATA_WIDTH-1:0] divisor_reg, divisor_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  dbz_reg, dbz_next;

    logic cmp_gt, cmp_lt, cmp_eq;

    generate
        if (SIGNED_CMP) begin : g_signed_cmp
            assign cmp_gt = $signed(rs) > $signed(rt);
            assign cmp_lt = $signed(rs) < $signed(rt);
        end else begin : g_unsigned_cmp
            assign cmp_gt = rs > rt;
            assign cmp_lt = rs < rt;
        end
    endgenerate
    assign cmp_eq = (rs == rt);

    // One restoring step: shift the next dividend bit into the partial remainder.
    // The partial remainder is always below the divisor, so the difference fits DATA_WIDTH bits.
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH-1:0] rem_diff;
    logic                  rem_ge;
    assign rem_shift = {rem_reg, quot_reg[DATA_WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor_reg};
    assign rem_diff  = rem_shift[DATA_WIDTH-1:0] - divisor_reg;

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        divisor_next = divisor_reg;
        count_next   = count_reg;
        dbz_next     = dbz_reg;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = enable && !reset;
                if (req_valid && enable) begin
                    dbz_next   = 1'b0;
                    state_next = DONE;
                    if (req_cmp) begin
                        result_next      = '0;
                        result_next[2:0] = {cmp_gt, cmp_eq, cmp_lt};
                    end else begin
                        case (req_op)
                            2'b00: result_next = rs + rt;
                            2'b01: result_next = rs - rt;
                            2'b10: result_next = rs * rt;
                            default: begin
                                if (rt == '0) begin
                                    result_next = '1;
                                    dbz_next    = 1'b1;
                                end else begin
                                    quot_next    = rs;
                                    rem_next     = '0;
                                    divisor_next = rt;
                                    count_next   = CW'(DATA_WIDTH);
                                    state_next   = DIVIDE;
                                end
                            end
                        endcase
                    end
                end
            end
            DIVIDE: begin
                quot_next  = {quot_reg[DATA_WIDTH-2:0], rem_ge};
                rem_next   = rem_ge ? rem_diff : rem_shift[DATA_WIDTH-1:0];
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    result_next = quot_next;
                    state_next  = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            count_reg   <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            divisor_reg <= divisor_next;
            count_reg   <= count_next;
            dbz_reg     <= dbz_next;
        end
    end

    assign result      = result_reg;
    assign div_by_zero = dbz_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: a signed-compare and an unsigned-compare instance
// share stimulus and are both checked against an arithmetic reference model.
module tb_alu_iterative;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_cmp = 1'b0;
    logic          resp_ready = 1'b0;
    logic [1:0]    req_op = 2'd0;
    logic [DW-1:0] rs = '0;
    logic [DW-1:0] rt = '0;

    logic          req_ready_s, resp_valid_s, dbz_s, busy_s;
    logic [DW-1:0] result_s;
    logic          req_ready_u, resp_valid_u, dbz_u, busy_u;
    logic [DW-1:0] result_u;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [8:0] s;
        logic [8:0] u;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_iterative #(.DATA_WIDTH(DW), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready_s),
        .req_op(req_op), .req_cmp(req_cmp), .rs(rs), .rt(rt),
        .resp_valid(resp_valid_s), .resp_ready(resp_ready),
        .result(result_s), .div_by_zero(dbz_s), .busy(busy_s)
    );

    alu_iterative #(.DATA_WIDTH(DW), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready_u),
        .req_op(req_op), .req_cmp(req_cmp), .rs(rs), .rt(rt),
        .resp_valid(resp_valid_u), .resp_ready(resp_ready),
        .result(result_u), .div_by_zero(dbz_u), .busy(busy_u)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {div_by_zero, result} from plain integer arithmetic.
    function automatic logic [8:0] model(input logic [1:0] op, input logic cmp,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input bit sgn);
        int ia, ib;
        if (sgn) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        if (cmp) begin
            if (ia > ib) return 9'h004;
            if (ia == ib) return 9'h002;
            return 9'h001;
        end
        case (op)
            2'd0: return 9'((int'(a) + int'(b)) & 255);
            2'd1: return 9'((int'(a) - int'(b) + 256) & 255);
            2'd2: return 9'((int'(a) * int'(b)) & 255);
            default: begin
                if (b == 8'd0) return 9'h1FF;
                return 9'(int'(a) / int'(b));
            end
        endcase
    endfunction

    // Checks both instances against the head of the expectation queue on every response cycle.
    always @(negedge clk) begin
        if (!reset && resp_valid_s) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", 32'(resp_valid_s), 32'd0);
            end else begin
                check("resp_signed_inst", {23'd0, dbz_s, result_s}, {23'd0, exp_q[0].s});
                check("resp_unsigned_inst", {23'd0, dbz_u, result_u}, {23'd0, exp_q[0].u});
                check("req_ready_low_in_done", 32'(req_ready_s), 32'd0);
                if (resp_ready) exp_q.pop_front();
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic cmp,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] lit_s, input logic [8:0] lit_u,
                          input int exp_lat, input int hold, input int drop_en);
        exp_t e;
        int   lat;
        bit   got;
        e.s = model(op, cmp, a, b, 1'b1);
        e.u = model(op, cmp, a, b, 1'b0);
        check({name, "_model_s"}, 32'(e.s), 32'(lit_s));
        check({name, "_model_u"}, 32'(e.u), 32'(lit_u));

        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_cmp = cmp; rs = a; rt = b;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready_s;
        end
        if (!got) begin
            check({name, "_accept_timeout"}, 32'(got), 32'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;

        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            lat++;
            if (lat == drop_en) enable = 1'b0;
            @(negedge clk);
            got = resp_valid_s;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (!got) begin
            exp_q.delete();
            enable = 1'b1;
            return;
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_req_ready"}, 32'(req_ready_s), 32'd0);
            check({name, "_hold_resp_valid"}, 32'(resp_valid_s), 32'd1);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check({name, "_resp_valid_drop"}, 32'(resp_valid_s), 32'd0);
        check({name, "_busy_drop"}, 32'(busy_s), 32'd0);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready_s), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_s), 32'd0);
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_result", 32'(result_s), 32'd0);
        check("rst_dbz", 32'(dbz_s), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready_s), 32'd1);

        //      name         op    cmp   rs     rt     exp_s    exp_u    lat hold drop
        run_op("add_wrap",  2'd0, 1'b0, 8'd200, 8'd100, 9'd44,  9'd44,   1, 0, -1);
        run_op("mul_wrap",  2'd2, 1'b0, 8'd20,  8'd13,  9'd4,   9'd4,    1, 0, -1);
        run_op("mul_ff",    2'd2, 1'b0, 8'd255, 8'd255, 9'd1,   9'd1,    1, 0, -1);
        run_op("sub_wrap",  2'd1, 1'b0, 8'd3,   8'd5,   9'd254, 9'd254,  1, 1, -1);
        run_op("div_200_7", 2'd3, 1'b0, 8'd200, 8'd7,   9'd28,  9'd28,   9, 3, -1);
        run_op("div_zero",  2'd3, 1'b0, 8'd5,   8'd0,   9'h1FF, 9'h1FF,  1, 0, -1);
        run_op("div_255_1", 2'd3, 1'b0, 8'd255, 8'd1,   9'd255, 9'd255,  9, 0, -1);
        run_op("div_small", 2'd3, 1'b0, 8'd7,   8'd200, 9'd0,   9'd0,    9, 0, -1);
        run_op("cmp_ff_01", 2'd0, 1'b1, 8'hFF,  8'h01,  9'h001, 9'h004,  1, 0, -1);
        run_op("cmp_eq",    2'd3, 1'b1, 8'h42,  8'h42,  9'h002, 9'h002,  1, 0, -1);
        run_op("cmp_80_7f", 2'd1, 1'b1, 8'h80,  8'h7F,  9'h001, 9'h004,  1, 0, -1);

        // Reset in the middle of a divide aborts it without a response.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd3; req_cmp = 1'b0; rs = 8'd200; rt = 8'd7;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready_s;
        end
        check("abort_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy_s), 32'd0);
        check("abort_resp_valid", 32'(resp_valid_s), 32'd0);
        check("abort_result", 32'(result_s), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("add_after_abort", 2'd0, 1'b0, 8'd1, 8'd1, 9'd2, 9'd2, 1, 0, -1);

        // enable low in IDLE blocks requests.
        @(posedge clk); #1;
        enable = 1'b0; req_valid = 1'b1; req_op = 2'd0; req_cmp = 1'b0; rs = 8'd1; rt = 8'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("disabled_req_ready", 32'(req_ready_s), 32'd0);
            check("disabled_resp_valid", 32'(resp_valid_s), 32'd0);
            check("disabled_busy", 32'(busy_s), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; enable = 1'b1;

        // Dropping enable mid-divide still delivers the quotient.
        run_op("div_en_drop", 2'd3, 1'b0, 8'd250, 8'd3, 9'd83, 9'd83, 9, 1, 3);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
